// File: rtl/montgomery_array_ctrl.sv
// montgomery_array_ctrl: command-driven controller for NUM_CORES parallel
// bit-serial Montgomery multipliers (result = A*B*2^-WIDTH mod M).
// Optional build macro: MONT_ARRAY_TIMEOUT_EN adds a 24-bit MULT_WAIT
// watchdog that returns status 2 and pulses a reset into every core.

// Radix-2 Montgomery multiplier, one bit of A per cycle.
// Needs odd M with A, B < M; the partial sum stays below 2M.
module montgomery_core #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   s_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_red;
  logic [WIDTH:0]   s_next;
  logic [WIDTH:0]   s_sub;

  // One Montgomery step: add a_i*B, make even by adding M, halve.
  always_comb begin
    t_add  = {1'b0, s_reg} + (a_reg[0] ? {2'b00, b} : '0);
    t_red  = t_add[0] ? (t_add + {2'b00, m}) : t_add;
    s_next = t_red[WIDTH+1:1];
    s_sub  = s_reg - {1'b0, m};
  end

  // Iterate WIDTH steps, then apply the final conditional subtraction.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
      s_reg    <= '0;
      a_reg    <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy_reg) begin
        if (start) begin
          busy_reg <= 1'b1;
          cnt_reg  <= '0;
          s_reg    <= '0;
          a_reg    <= a;
        end
      end else if (cnt_reg == CW'(WIDTH)) begin
        busy_reg <= 1'b0;
        done     <= 1'b1;
        result   <= (s_reg >= {1'b0, m}) ? s_sub[WIDTH-1:0] : s_reg[WIDTH-1:0];
      end else begin
        s_reg   <= s_next;
        a_reg   <= a_reg >> 1;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
endmodule

module montgomery_array_ctrl #(
  parameter int NUM_CORES = 2,
  parameter int WIDTH     = 512
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_CORES*WIDTH-1:0] bram_din,
  input  logic                       bram_din_valid,
  output logic [NUM_CORES*WIDTH-1:0] bram_dout,
  output logic                       bram_dout_valid,
  input  logic                       bram_dout_read,
  input  logic [31:0]                port1_din,
  input  logic                       port1_valid,
  output logic                       port1_read,
  output logic [31:0]                port2_dout,
  output logic                       port2_valid,
  input  logic                       port2_read,
  output logic [3:0]                 leds
);
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd1,
    ST_READ       = 3'd2,
    ST_MULT_START = 3'd3,
    ST_MULT_WAIT  = 3'd4,
    ST_CAPTURE    = 3'd5,
    ST_WRITE      = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  localparam logic [3:0]  OP_READ_A   = 4'd0;
  localparam logic [3:0]  OP_READ_B   = 4'd1;
  localparam logic [3:0]  OP_READ_M   = 4'd2;
  localparam logic [3:0]  OP_MULTIPLY = 4'd3;
  localparam logic [3:0]  OP_WRITE    = 4'd4;
  localparam logic [31:0] STATUS_OK      = 32'd0;
  localparam logic [31:0] STATUS_BADCMD  = 32'd1;
`ifdef MONT_ARRAY_TIMEOUT_EN
  localparam logic [31:0] STATUS_TIMEOUT = 32'd2;
`endif

  state_t                     state_reg;
  logic [3:0]                 opcode_reg;
  logic [NUM_CORES-1:0]       mask_reg;
  logic [31:0]                status_reg;
  logic [NUM_CORES*WIDTH-1:0] a_bank_reg;
  logic [NUM_CORES*WIDTH-1:0] b_bank_reg;
  logic [NUM_CORES*WIDTH-1:0] m_bank_reg;
  logic [NUM_CORES-1:0]       sticky_reg;
  logic [NUM_CORES-1:0]       start_reg;

  logic [NUM_CORES-1:0]       cmd_mask_raw;
  logic [NUM_CORES-1:0]       cmd_mask;
  logic [NUM_CORES-1:0]       sticky_next;
  logic                       all_done;
  logic [NUM_CORES*WIDTH-1:0] capture_data;
  logic [NUM_CORES*WIDTH-1:0] core_result;
  logic [NUM_CORES-1:0]       core_done;
  logic                       core_rst;
  logic                       unused_cmd_bits;

`ifdef MONT_ARRAY_TIMEOUT_EN
  logic [23:0] timeout_cnt_reg;
  logic        core_reset_reg;
  assign core_rst = !resetn || core_reset_reg;
`else
  assign core_rst = !resetn;
`endif

  // Only the low NUM_CORES mask bits matter; an empty mask selects every lane.
  assign cmd_mask_raw    = port1_din[NUM_CORES+15:16];
  assign cmd_mask        = (cmd_mask_raw == '0) ? '1 : cmd_mask_raw;
  assign unused_cmd_bits = ^port1_din;

  assign sticky_next = sticky_reg | (core_done & mask_reg);
  assign all_done    = ((sticky_next & mask_reg) == mask_reg);
  assign leds        = {1'b0, state_reg};

  // Per-lane core instances and capture muxes (unmasked lanes keep old data).
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
      montgomery_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (core_rst),
        .start  (start_reg[gi]),
        .a      (a_bank_reg[gi*WIDTH +: WIDTH]),
        .b      (b_bank_reg[gi*WIDTH +: WIDTH]),
        .m      (m_bank_reg[gi*WIDTH +: WIDTH]),
        .result (core_result[gi*WIDTH +: WIDTH]),
        .done   (core_done[gi])
      );
      assign capture_data[gi*WIDTH +: WIDTH] = mask_reg[gi] ?
          core_result[gi*WIDTH +: WIDTH] : bram_dout[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Main controller FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      opcode_reg      <= '0;
      mask_reg        <= '0;
      status_reg      <= '0;
      a_bank_reg      <= '0;
      b_bank_reg      <= '0;
      m_bank_reg      <= '0;
      sticky_reg      <= '0;
      start_reg       <= '0;
      port1_read      <= 1'b0;
      port2_valid     <= 1'b0;
      port2_dout      <= '0;
      bram_dout       <= '0;
      bram_dout_valid <= 1'b0;
`ifdef MONT_ARRAY_TIMEOUT_EN
      timeout_cnt_reg <= '0;
      core_reset_reg  <= 1'b0;
`endif
    end else begin
      port1_read <= 1'b0;
      start_reg  <= '0;
`ifdef MONT_ARRAY_TIMEOUT_EN
      core_reset_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (port1_valid) begin
            port1_read <= 1'b1;
            opcode_reg <= port1_din[3:0];
            mask_reg   <= cmd_mask;
            case (port1_din[3:0])
              OP_READ_A, OP_READ_B, OP_READ_M: state_reg <= ST_READ;
              OP_MULTIPLY:                     state_reg <= ST_MULT_START;
              OP_WRITE:                        state_reg <= ST_WRITE;
              default: begin
                status_reg <= STATUS_BADCMD;
                state_reg  <= ST_DONE;
              end
            endcase
          end
        end
        ST_READ: begin
          if (bram_din_valid) begin
            case (opcode_reg)
              OP_READ_A: a_bank_reg <= bram_din;
              OP_READ_B: b_bank_reg <= bram_din;
              default:   m_bank_reg <= bram_din;
            endcase
            status_reg <= STATUS_OK;
            state_reg  <= ST_DONE;
          end
        end
        ST_MULT_START: begin
          sticky_reg <= '0;
          start_reg  <= mask_reg;
`ifdef MONT_ARRAY_TIMEOUT_EN
          timeout_cnt_reg <= '0;
`endif
          state_reg  <= ST_MULT_WAIT;
        end
        ST_MULT_WAIT: begin
          sticky_reg <= sticky_next;
          if (all_done) begin
            state_reg <= ST_CAPTURE;
`ifdef MONT_ARRAY_TIMEOUT_EN
          end else if (timeout_cnt_reg == 24'hFFFFFF) begin
            status_reg     <= STATUS_TIMEOUT;
            core_reset_reg <= 1'b1;
            state_reg      <= ST_DONE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 24'd1;
`endif
          end
        end
        ST_CAPTURE: begin
          bram_dout  <= capture_data;
          status_reg <= STATUS_OK;
          state_reg  <= ST_DONE;
        end
        ST_WRITE: begin
          if (!bram_dout_valid) begin
            bram_dout_valid <= 1'b1;
          end else if (bram_dout_read) begin
            bram_dout_valid <= 1'b0;
            status_reg      <= STATUS_OK;
            state_reg       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!port2_valid) begin
            port2_valid <= 1'b1;
            port2_dout  <= status_reg;
          end else if (port2_read) begin
            port2_valid <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_montgomery_array_ctrl.sv
// Scoreboard bench for montgomery_array_ctrl (NUM_CORES=2, WIDTH=8, R=256).
// Expected Montgomery products are hand-computed as A*B*256^-1 mod M.
module tb_montgomery_array_ctrl;
  localparam int NC = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NC*W-1:0] bram_din = '0;
  logic            bram_din_valid = 1'b0;
  logic [NC*W-1:0] bram_dout;
  logic            bram_dout_valid;
  logic            bram_dout_read = 1'b0;
  logic [31:0]     port1_din = '0;
  logic            port1_valid = 1'b0;
  logic            port1_read;
  logic [31:0]     port2_dout;
  logic            port2_valid;
  logic            port2_read = 1'b0;
  logic [3:0]      leds;

  int errors = 0;
  int checks = 0;
  logic [31:0]     status_q[$];
  logic [NC*W-1:0] dout_q[$];

  montgomery_array_ctrl #(.NUM_CORES(NC), .WIDTH(W)) dut (
    .clk(clk), .resetn(resetn),
    .bram_din(bram_din), .bram_din_valid(bram_din_valid),
    .bram_dout(bram_dout), .bram_dout_valid(bram_dout_valid),
    .bram_dout_read(bram_dout_read),
    .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
    .port2_dout(port2_dout), .port2_valid(port2_valid), .port2_read(port2_read),
    .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Status monitor: consumes port2 and compares against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && port2_valid && !port2_read) begin
        if (status_q.size() == 0) begin
          check("port2 unexpected valid", port2_valid, 1'b0);
        end else begin
          logic [31:0] exp_s;
          exp_s = status_q.pop_front();
          check("port2 status", port2_dout, exp_s);
          $display("status  got=%0d exp=%0d", port2_dout, exp_s);
        end
        port2_read = 1'b1;
      end else begin
        port2_read = 1'b0;
      end
    end
  end

  // Result monitor: compares bram_dout on each rising bram_dout_valid.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bram_dout_valid && !prev_valid) begin
        if (dout_q.size() == 0) begin
          check("bram unexpected valid", bram_dout_valid, 1'b0);
        end else begin
          logic [NC*W-1:0] exp_d;
          exp_d = dout_q.pop_front();
          check("bram_dout result", bram_dout, exp_d);
          $display("write   got=%h exp=%h", bram_dout, exp_d);
        end
      end
      prev_valid = bram_dout_valid;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (leds != 4'd1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, " return to idle"}, leds, 4'd1);
  endtask

  task automatic send_cmd(input logic [31:0] cmd);
    @(negedge clk);
    port1_din   = cmd;
    port1_valid = 1'b1;
    @(negedge clk);
    port1_valid = 1'b0;
    port1_din   = 32'h0000_0000;
    check("port1_read high", port1_read, 1'b1);
    @(negedge clk);
    check("port1_read one cycle", port1_read, 1'b0);
    $display("cmd     %h issued", cmd);
  endtask

  task automatic read_cmd(input logic [3:0] op, input logic [W-1:0] l1, input logic [W-1:0] l0);
    status_q.push_back(32'd0);
    bram_din = 16'hDEAD;
    send_cmd({28'd0, op});
    repeat (10) @(negedge clk);
    check("read stall state", leds, 4'd2);
    bram_din       = {l1, l0};
    bram_din_valid = 1'b1;
    @(negedge clk);
    bram_din_valid = 1'b0;
    bram_din       = 16'hBEEF;
    wait_idle("read");
  endtask

  task automatic mult_cmd(input logic [31:0] cmd);
    status_q.push_back(32'd0);
    send_cmd(cmd);
    wait_idle("multiply");
  endtask

  task automatic write_cmd(input logic [NC*W-1:0] exp, input int hold);
    int n;
    dout_q.push_back(exp);
    status_q.push_back(32'd0);
    send_cmd(32'd4);
    n = 0;
    while (!bram_dout_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < hold; i++) begin
      check("write valid held", bram_dout_valid, 1'b1);
      check("write data stable", bram_dout, exp);
      @(negedge clk);
    end
    bram_dout_read = 1'b1;
    @(negedge clk);
    bram_dout_read = 1'b0;
    check("write valid dropped", bram_dout_valid, 1'b0);
    wait_idle("write");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset leds", leds, 4'd1);
    check("reset port1_read", port1_read, 1'b0);
    check("reset port2_valid", port2_valid, 1'b0);
    check("reset port2_dout", port2_dout, 32'd0);
    check("reset bram_dout_valid", bram_dout_valid, 1'b0);
    check("reset bram_dout", bram_dout, 16'h0000);
    resetn = 1'b1;

    // Bad commands, including one with mask bits set.
    status_q.push_back(32'd1);
    send_cmd(32'h0000_0009);
    wait_idle("badcmd");
    status_q.push_back(32'd1);
    send_cmd(32'hFFFF_000F);
    wait_idle("badcmd2");

    // Operands: lane0 (3,5,7) -> 2, lane1 (2,2,11) -> 5.
    read_cmd(4'd0, 8'd2, 8'd3);
    read_cmd(4'd1, 8'd2, 8'd5);
    read_cmd(4'd2, 8'd11, 8'd7);
    mult_cmd(32'h0000_0003);
    write_cmd(16'h0502, 20);

    // New A: lane0 6 -> 4, lane1 7 -> 1. Lane1-only multiply keeps lane0 at 2.
    read_cmd(4'd0, 8'd7, 8'd6);
    mult_cmd(32'h0002_0003);
    write_cmd(16'h0102, 3);

    // Mask bit above NUM_CORES only: effective mask is empty, so all lanes.
    mult_cmd(32'h0004_0003);
    write_cmd(16'h0104, 1);

    // Reset during MULT_WAIT aborts without status and clears results.
    send_cmd(32'h0000_0003);
    repeat (3) @(negedge clk);
    check("mult wait state", leds, 4'd4);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset leds", leds, 4'd1);
    check("midreset port2_valid", port2_valid, 1'b0);
    check("midreset bram_dout", bram_dout, 16'h0000);
    check("midreset bram_dout_valid", bram_dout_valid, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge clk);
      check("no status after reset", port2_valid, 1'b0);
    end
    check("idle after reset", leds, 4'd1);
    write_cmd(16'h0000, 2);

    repeat (5) @(negedge clk);
    check("status queue drained", status_q.size(), 0);
    check("result queue drained", dout_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
